// File: rtl/warmboot_seq_pkg.sv
// Shared types for the warm-boot request sequencer: slot index type, FSM
// state encoding and the slot range check.
package warmboot_seq_pkg;

  typedef logic [3:0] slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } seq_state_e;

  function automatic logic slot_ok(input slot_t slot, input slot_t max_slot);
    return slot <= max_slot;
  endfunction

endpackage

// File: rtl/wb_debounce.sv
// Button conditioning: 2-FF synchroniser, level debouncer and a one-cycle
// press pulse registered together with the debounced rising edge.
module wb_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int DW = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 16'd1);

  logic          btn_s1;
  logic          btn_s2;
  logic          level;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      press  <= 1'b0;
      // Count consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the window.
      if (btn_s2 != level) begin
        if (stable_cnt == DB_LAST) begin
          level      <= btn_s2;
          stable_cnt <= '0;
          press      <= btn_s2;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/warmboot_sequencer.sv
// Warm-boot request sequencer: debounced press latches a validated slot, runs
// a countdown, then holds slot_o/boot_o. Optional WARMBOOT_SEQ_ABORT_EN lets a
// second press during the countdown cancel the request.
//
//   state | meaning
//   IDLE  | waiting for a press; invalid slot sets err_o and stays here
//   ARMED | slot latched, countdown running, busy_o high
//   FIRE  | boot_o high, slot_o frozen; only reset leaves
module warmboot_sequencer
  import warmboot_seq_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd1000,
  parameter logic [23:0] COUNTDOWN_CYCLES = 24'd1_000_000,
  parameter slot_t       MAX_SLOT         = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic [3:0] slot_sel_i,
  output logic [3:0] slot_o,
  output logic       boot_o,
  output logic       busy_o,
  output logic       err_o,
  output logic       count_msb_o
);

  localparam int CW = $clog2(int'(COUNTDOWN_CYCLES) + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNTDOWN_CYCLES - 24'd1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(COUNTDOWN_CYCLES);

  logic          press;
  slot_t         slot_s1;
  slot_t         slot_s2;
  seq_state_e    state;
  logic [CW-1:0] cnt;

  wb_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_i),
    .press(press)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_s1 <= '0;
      slot_s2 <= '0;
    end else begin
      slot_s1 <= slot_sel_i;
      slot_s2 <= slot_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      slot_o <= '0;
      boot_o <= 1'b0;
      busy_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            if (slot_ok(slot_s2, MAX_SLOT)) begin
              slot_o <= slot_s2;
              cnt    <= '0;
              err_o  <= 1'b0;
              busy_o <= 1'b1;
              state  <= ARMED;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ARMED: begin
`ifdef WARMBOOT_SEQ_ABORT_EN
          // Abort is checked first so it also beats the final count.
          if (press) begin
            cnt    <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else
`endif
          begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              boot_o <= 1'b1;
              state  <= FIRE;
            end
          end
        end
        FIRE: begin
          boot_o <= 1'b1;
          busy_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count_msb_o = cnt[CW-1];

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: window-based behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_warmboot_sequencer;

  localparam int D = 4;
  localparam int C = 10;
  localparam int MAXS = 3;
  localparam int CW = $clog2(C + 1);
`ifdef WARMBOOT_SEQ_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       btn_i;
  logic [3:0] slot_sel_i;
  logic [3:0] slot_o;
  logic       boot_o;
  logic       busy_o;
  logic       err_o;
  logic       count_msb_o;

  int n_checks = 0;
  int n_fail   = 0;

  warmboot_sequencer #(
    .DEBOUNCE_CYCLES (16'd4),
    .COUNTDOWN_CYCLES(24'd10),
    .MAX_SLOT        (4'd3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_i      (btn_i),
    .slot_sel_i (slot_sel_i),
    .slot_o     (slot_o),
    .boot_o     (boot_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .count_msb_o(count_msb_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: raw input history; the debouncer sees a sample two edges late and
  // flips when the last D seen samples all differ from the current level.
  logic       bh [0:D];
  logic [3:0] sh [0:1];
  logic       m_level, m_press, m_valid;
  int         m_phase;  // 0 idle, 1 counting, 2 fired
  int         edge_n, arm_edge;
  logic [3:0] m_slot;
  logic       m_err;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    logic all_diff;
    edge_n++;
    if (!rst_n) begin
      for (int i = 0; i <= D; i++) bh[i] = 1'b0;
      sh[0] = '0; sh[1] = '0;
      m_level = 1'b0; m_press = 1'b0;
      m_phase = 0; m_slot = '0; m_err = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (m_phase == 0) begin
        if (m_press) begin
          if (int'(sh[1]) <= MAXS) begin
            m_slot = sh[1]; m_err = 1'b0; m_phase = 1; arm_edge = edge_n;
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (m_phase == 1) begin
        if (ABORT && m_press) m_phase = 0;
        else if (edge_n - arm_edge >= C) m_phase = 2;
      end
      all_diff = 1'b1;
      for (int i = 1; i <= D; i++) if (bh[i] == m_level) all_diff = 1'b0;
      m_press = 1'b0;
      if (all_diff) begin
        m_level = ~m_level;
        m_press = m_level;
      end
      for (int i = D; i >= 1; i--) bh[i] = bh[i-1];
      bh[0] = btn_i;
      sh[1] = sh[0];
      sh[0] = slot_sel_i;
    end
  end

  always @(negedge clk) begin
    int cval;
    if (m_valid) begin
      cval = 0;
      if (m_phase != 0) cval = (edge_n - arm_edge < C) ? edge_n - arm_edge : C;
      chk("cmp_slot", 8'(slot_o), 8'(m_slot));
      chk("cmp_boot", 8'(boot_o), 8'(m_phase == 2));
      chk("cmp_busy", 8'(busy_o), 8'(m_phase != 0));
      chk("cmp_err",  8'(err_o),  8'(m_err));
      chk("cmp_msb",  8'(count_msb_o), 8'(cval >= (1 << (CW - 1))));
    end
  end

  initial begin
    edge_n = 0;
    arm_edge = 0;
    rst_n = 1'b0; btn_i = 1'b0; slot_sel_i = 4'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(100);
    chk("idle_outputs", {3'b0, slot_o, boot_o}, 8'd0);
    chk("idle_flags", {5'b0, busy_o, err_o, count_msb_o}, 8'd0);

    // Clean press on slot 2; N0 is the negedge the button rises on.
    slot_sel_i = 4'd2; cyc(3);
    btn_i = 1'b1;
    cyc(6); chk("busy_before_latch", 8'(busy_o), 8'd0);
    cyc(1); chk("slot_at_7", 8'(slot_o), 8'd2);
            chk("busy_at_7", 8'(busy_o), 8'd1);
    cyc(9); chk("boot_at_16", 8'(boot_o), 8'd0);
    cyc(1); chk("boot_at_17", 8'(boot_o), 8'd1);
    cyc(3); btn_i = 1'b0;
    cyc(10);
    slot_sel_i = 4'd3; cyc(5); slot_sel_i = 4'd0; cyc(5); slot_sel_i = 4'd1; cyc(5);
    chk("slot_held_fire", 8'(slot_o), 8'd2);
    chk("boot_held_fire", 8'(boot_o), 8'd1);

    // Press while fired is ignored.
    btn_i = 1'b1; cyc(20); btn_i = 1'b0; cyc(15);
    chk("fire_press_boot", 8'(boot_o), 8'd1);
    chk("fire_press_slot", 8'(slot_o), 8'd2);

    rst_n = 1'b0; cyc(1);
    chk("reset_from_fire", {slot_o, boot_o, busy_o, err_o, count_msb_o}, 8'd0);
    rst_n = 1'b1; slot_sel_i = 4'd0; cyc(5);

    // Bounce of 3-cycle pulses never reaches the debounce threshold.
    repeat (4) begin
      btn_i = 1'b1; cyc(3); btn_i = 1'b0; cyc(3);
    end
    cyc(10);
    chk("bounce_busy", 8'(busy_o), 8'd0);
    chk("bounce_err", 8'(err_o), 8'd0);

    // Out-of-range slot flags an error and stays idle.
    slot_sel_i = 4'd5; cyc(3);
    btn_i = 1'b1; cyc(10); btn_i = 1'b0; cyc(10);
    chk("bad_slot_err", 8'(err_o), 8'd1);
    chk("bad_slot_busy", 8'(busy_o), 8'd0);
    chk("bad_slot_slot", 8'(slot_o), 8'd0);
    chk("bad_slot_boot", 8'(boot_o), 8'd0);

    slot_sel_i = 4'd1; cyc(3);
    btn_i = 1'b1;
    cyc(7);  chk("err_cleared", 8'(err_o), 8'd0);
             chk("slot1_latched", 8'(slot_o), 8'd1);
    cyc(10); chk("slot1_boot", 8'(boot_o), 8'd1);
    btn_i = 1'b0; cyc(10);

    // Reset five cycles into the countdown.
    rst_n = 1'b0; cyc(2); rst_n = 1'b1;
    slot_sel_i = 4'd3; cyc(3);
    btn_i = 1'b1; cyc(6); btn_i = 1'b0; cyc(6);
    chk("armed_before_reset", 8'(busy_o), 8'd1);
    rst_n = 1'b0; cyc(1);
    chk("reset_mid_armed", {slot_o, boot_o, busy_o, err_o, count_msb_o}, 8'd0);
    rst_n = 1'b1; cyc(30);
    chk("no_boot_after_reset", 8'(boot_o), 8'd0);
    chk("idle_after_reset", 8'(busy_o), 8'd0);

    // Second press as early as debounce allows, while still counting (count 8).
    slot_sel_i = 4'd2; cyc(3);
    btn_i = 1'b1; cyc(4); btn_i = 1'b0; cyc(4);
    btn_i = 1'b1; cyc(6); btn_i = 1'b0;
    cyc(1); chk("second_press_busy", 8'(busy_o), ABORT ? 8'd0 : 8'd1);
    cyc(2); chk("second_press_boot", 8'(boot_o), ABORT ? 8'd0 : 8'd1);
            chk("second_press_slot", 8'(slot_o), 8'd2);
    cyc(30); chk("second_press_final", 8'(boot_o), ABORT ? 8'd0 : 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
